// File: rtl/audio_frame_sched_if.sv
// rtl/audio_frame_sched_if.sv - FM/PCM source and serial DAC signal bundle for audio_frame_sched.
interface audio_frame_sched_if #(
    parameter int FIFO_AW = 2
);
    logic [15:0]      i_FM_L;
    logic [15:0]      i_FM_R;
    logic             i_FM_VALID;
    logic             i_FM_EN;
    logic [31:0]      i_PCM_DATA;
    logic             i_PCM_WR;
    logic             i_PCM_EN;
    logic             i_CLR_UNDERRUN;
    logic             o_PCM_FULL;
    logic [FIFO_AW:0] o_PCM_LEVEL;
    logic             o_BCK;
    logic             o_LRCK;
    logic             o_DATA;
    logic             o_FRAME;
    logic             o_UNDERRUN;

    modport master (
        output i_FM_L, i_FM_R, i_FM_VALID, i_FM_EN,
        output i_PCM_DATA, i_PCM_WR, i_PCM_EN, i_CLR_UNDERRUN,
        input  o_PCM_FULL, o_PCM_LEVEL, o_BCK, o_LRCK, o_DATA, o_FRAME, o_UNDERRUN
    );

    modport slave (
        input  i_FM_L, i_FM_R, i_FM_VALID, i_FM_EN,
        input  i_PCM_DATA, i_PCM_WR, i_PCM_EN, i_CLR_UNDERRUN,
        output o_PCM_FULL, o_PCM_LEVEL, o_BCK, o_LRCK, o_DATA, o_FRAME, o_UNDERRUN
    );
endinterface

// File: rtl/audio_frame_sched.sv
// rtl/audio_frame_sched.sv - BCK/LRCK generator mixing FM and PCM FIFO audio into one serial DAC.
module audio_frame_sched #(
    parameter int BCK_DIV = 4,
    parameter int FIFO_AW = 2
) (
    input  logic                i_CLOCK,
    input  logic                i_RESET,
    audio_frame_sched_if.slave  bus
);
    localparam int                 DIV_W    = $clog2(BCK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam int                 DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_L  = (FIFO_AW + 1)'(DEPTH);

    logic [DIV_W-1:0]   div;
    logic               bck;
    logic [4:0]         bit_idx;
    logic               lrck;
    logic               frame;
    logic               underrun;
    logic [31:0]        shreg;
    logic [15:0]        fm_l;
    logic [15:0]        fm_r;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [FIFO_AW:0]   level_nxt;
    logic               full;

    logic               tick;
    logic               fall;
    logic               load;
    logic               pop;
    logic               und_set;
    logic               wr_acc;
    logic [31:0]        pcm_term;
    logic [15:0]        fm_term_l;
    logic [15:0]        fm_term_r;
    logic [31:0]        mix;

    // 17-bit signed add, clamped to the 16-bit range when the two top bits disagree.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15])
            return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
    endfunction

    assign tick      = (div == DIV_LAST);
    assign fall      = tick & bck;
    assign load      = fall & (bit_idx == 5'd31);
    assign pop       = load & bus.i_PCM_EN & (level != '0);
    assign und_set   = load & bus.i_PCM_EN & (level == '0);
    assign wr_acc    = bus.i_PCM_WR & ((level != DEPTH_L) | pop);
    assign level_nxt = level + {{FIFO_AW{1'b0}}, wr_acc} - {{FIFO_AW{1'b0}}, pop};

    // The FM latch is read before this clock's i_FM_VALID update lands, so a
    // coincident FM sample is only mixed from the following frame.
    assign pcm_term  = pop ? mem[rd_ptr] : 32'h0;
    assign fm_term_l = bus.i_FM_EN ? fm_l : 16'h0;
    assign fm_term_r = bus.i_FM_EN ? fm_r : 16'h0;
    assign mix       = {sat16(fm_term_l, pcm_term[31:16]), sat16(fm_term_r, pcm_term[15:0])};

    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            div      <= '0;
            bck      <= 1'b1;
            bit_idx  <= 5'd31;
            lrck     <= 1'b1;
            frame    <= 1'b0;
            underrun <= 1'b0;
            shreg    <= 32'h0;
            fm_l     <= 16'h0;
            fm_r     <= 16'h0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
        end else begin
            div   <= tick ? '0 : div + 1'b1;
            frame <= load;
            if (tick)
                bck <= ~bck;
            if (fall) begin
                bit_idx <= bit_idx + 5'd1;
                if (load) begin
                    shreg <= mix;
                    lrck  <= 1'b1;
                end else begin
                    shreg <= {shreg[30:0], 1'b0};
                    if (bit_idx == 5'd15)
                        lrck <= 1'b0;
                end
            end
            if (bus.i_FM_VALID) begin
                fm_l <= bus.i_FM_L;
                fm_r <= bus.i_FM_R;
            end
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == DEPTH_L);
            if (und_set)
                underrun <= 1'b1;
            else if (bus.i_CLR_UNDERRUN)
                underrun <= 1'b0;
        end
    end

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge i_CLOCK) begin
        if (!i_RESET && wr_acc)
            mem[wr_ptr] <= bus.i_PCM_DATA;
    end

    assign bus.o_BCK       = bck;
    assign bus.o_LRCK      = lrck;
    assign bus.o_DATA      = shreg[31];
    assign bus.o_FRAME     = frame;
    assign bus.o_UNDERRUN  = underrun;
    assign bus.o_PCM_LEVEL = level;
    assign bus.o_PCM_FULL  = full;
endmodule

// File: tb/tb_audio_frame_sched.sv
// tb/tb_audio_frame_sched.sv - randomized bench for audio_frame_sched against a frame-level reference model.
module tb_audio_frame_sched;
    localparam int BCK_DIV = 2;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    audio_frame_sched_if #(.FIFO_AW(FIFO_AW)) bus ();

    audio_frame_sched #(.BCK_DIV(BCK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .i_CLOCK (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: n counts clocks since reset release (-1 while in reset).
    int          n;
    logic [31:0] q [$];
    logic [15:0] m_fl, m_fr;
    logic        m_und;
    logic [31:0] m_word;
    int          m_bit;
    logic        m_fall, m_load;
    logic        e_bck, e_lrck, e_data, e_frame;

    function automatic logic [15:0] ref_sat(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // Clock m is a frame load when BCK's toggle number is odd (a fall) and that
    // fall is the 1st, 33rd, 65th ... since reset.
    function automatic bit is_load(int m);
        int t;
        t = (m + 1) / BCK_DIV;
        return ((m + 1) % BCK_DIV == 0) && (t % 2 == 1) && ((((t + 1) / 2) - 1) % 32 == 0);
    endfunction

    function automatic logic [8:0] obs_vec();
        return {bus.o_BCK, bus.o_LRCK, bus.o_DATA, bus.o_FRAME, bus.o_UNDERRUN,
                bus.o_PCM_FULL, bus.o_PCM_LEVEL};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {e_bck, e_lrck, e_data, e_frame, m_und, q.size() == DEPTH, 3'(q.size())};
    endfunction

    task automatic tick();
        logic        set_und;
        logic        popped;
        logic [31:0] pe;
        @(posedge clk);
        m_load = 1'b0;
        m_fall = 1'b0;
        if (rst) begin
            n = -1; q.delete(); m_fl = 16'h0; m_fr = 16'h0; m_und = 1'b0;
            m_word = 32'h0; m_bit = 31;
            e_bck = 1'b1; e_lrck = 1'b1; e_data = 1'b0; e_frame = 1'b0;
        end else begin
            n++;
            m_fall  = ((n + 1) % BCK_DIV == 0) && ((((n + 1) / BCK_DIV) % 2) == 1);
            m_load  = is_load(n);
            set_und = 1'b0;
            popped  = 1'b0;
            pe      = 32'h0;
            if (m_load) begin
                if (bus.i_PCM_EN) begin
                    if (q.size() > 0) begin
                        pe = q.pop_front();
                        popped = 1'b1;
                    end else begin
                        set_und = 1'b1;
                    end
                end
                m_word = {ref_sat(bus.i_FM_EN ? m_fl : 16'h0, pe[31:16]),
                          ref_sat(bus.i_FM_EN ? m_fr : 16'h0, pe[15:0])};
            end
            if (bus.i_PCM_WR && (q.size() < DEPTH || popped))
                q.push_back(bus.i_PCM_DATA);
            if (bus.i_FM_VALID) begin
                m_fl = bus.i_FM_L;
                m_fr = bus.i_FM_R;
            end
            if (set_und) m_und = 1'b1;
            else if (bus.i_CLR_UNDERRUN) m_und = 1'b0;
            e_bck   = ((((n + 1) / BCK_DIV) % 2) == 0);
            e_frame = m_load;
            if (m_fall) begin
                m_bit  = (m_bit + 1) % 32;
                e_data = m_word[31 - m_bit];
                e_lrck = (m_bit < 16);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_FM_L = 16'h0; bus.i_FM_R = 16'h0; bus.i_FM_VALID = 1'b0; bus.i_FM_EN = 1'b0;
        bus.i_PCM_DATA = 32'h0; bus.i_PCM_WR = 1'b0; bus.i_PCM_EN = 1'b0; bus.i_CLR_UNDERRUN = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Collects the 32 serial bits of the frame that starts at the current or next load.
    task automatic capture_frame(output logic [31:0] w);
        int got;
        for (int i = 0; i < 400 && !m_load; i++) tick();
        w = {31'b0, bus.o_DATA};
        got = 1;
        for (int i = 0; i < 400 && got < 32; i++) begin
            tick();
            if (m_fall) begin
                w = {w[30:0], bus.o_DATA};
                got++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== 9'h180) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), 9'h180);
        end
        rst = 1'b0;
    endtask

    task automatic test_fm_only();
        logic [31:0] w;
        int last, per;
        do_reset();
        bus.i_FM_EN = 1'b1; bus.i_PCM_EN = 1'b0;
        bus.i_FM_L = 16'h1234; bus.i_FM_R = 16'hFEDC; bus.i_FM_VALID = 1'b1;
        tick();
        bus.i_FM_VALID = 1'b0;
        capture_frame(w);
        vectors++;
        if (w !== 32'h1234FEDC) begin
            miscompares++;
            $display("FAIL fm_only_word got=%h exp=%h", w, 32'h1234FEDC);
        end
        last = -1; per = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fm_only_cycle n=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
            end
            if (bus.o_FRAME) begin
                if (last >= 0) per = n - last;
                last = n;
            end
        end
        vectors++;
        if (per !== 64 * BCK_DIV) begin
            miscompares++;
            $display("FAIL frame_period got=%0d exp=%0d", per, 64 * BCK_DIV);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] w;
        do_reset();
        bus.i_FM_EN = 1'b1; bus.i_PCM_EN = 1'b0;
        bus.i_FM_L = 16'h7000; bus.i_FM_R = 16'h9000; bus.i_FM_VALID = 1'b1;
        tick();
        bus.i_FM_VALID = 1'b0;
        bus.i_PCM_WR = 1'b1; bus.i_PCM_DATA = 32'h2000E000;
        tick();
        bus.i_PCM_DATA = 32'hFFFFFFFF;
        tick();
        bus.i_PCM_WR = 1'b0; bus.i_PCM_EN = 1'b1;
        capture_frame(w);
        vectors++;
        if (w !== 32'h7FFF8000) begin
            miscompares++;
            $display("FAIL sat_clip got=%h exp=%h", w, 32'h7FFF8000);
        end
        bus.i_FM_L = 16'h0001; bus.i_FM_R = 16'h0001; bus.i_FM_VALID = 1'b1;
        tick();
        bus.i_FM_VALID = 1'b0;
        capture_frame(w);
        vectors++;
        if (w !== 32'h00000000) begin
            miscompares++;
            $display("FAIL sat_cancel got=%h exp=%h", w, 32'h00000000);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        bus.i_FM_EN = 1'b0; bus.i_PCM_EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_PCM_WR = 1'b1; bus.i_PCM_DATA = $urandom;
            tick();
        end
        bus.i_PCM_WR = 1'b0;
        vectors++;
        if ({bus.o_PCM_FULL, bus.o_PCM_LEVEL} !== 4'b1100) begin
            miscompares++;
            $display("FAIL fifo_full got=%b exp=%b", {bus.o_PCM_FULL, bus.o_PCM_LEVEL}, 4'b1100);
        end
        bus.i_PCM_EN = 1'b1;
        for (int i = 0; i < 5 * 64 * BCK_DIV + 20; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fifo_drain n=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_write_at_pop();
        do_reset();
        bus.i_FM_EN = 1'b1; bus.i_PCM_EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_PCM_WR = 1'b1; bus.i_PCM_DATA = $urandom;
            tick();
        end
        bus.i_PCM_WR = 1'b0;
        bus.i_PCM_EN = 1'b1;
        for (int i = 0; i < 400 && !is_load(n + 1); i++) tick();
        bus.i_PCM_WR = 1'b1; bus.i_PCM_DATA = $urandom;
        tick();
        bus.i_PCM_WR = 1'b0;
        vectors++;
        if ({bus.o_FRAME, bus.o_PCM_FULL, bus.o_PCM_LEVEL} !== 5'b11100) begin
            miscompares++;
            $display("FAIL write_at_pop got=%b exp=%b",
                     {bus.o_FRAME, bus.o_PCM_FULL, bus.o_PCM_LEVEL}, 5'b11100);
        end
        for (int i = 0; i < 5 * 64 * BCK_DIV; i++) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL write_at_pop_order n=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] w;
        do_reset();
        bus.i_FM_EN = 1'b1; bus.i_PCM_EN = 1'b1;
        bus.i_FM_L = 16'h0100; bus.i_FM_R = 16'h0200; bus.i_FM_VALID = 1'b1;
        tick();
        bus.i_FM_VALID = 1'b0;
        capture_frame(w);
        vectors++;
        if ({w, bus.o_UNDERRUN} !== {32'h01000200, 1'b1}) begin
            miscompares++;
            $display("FAIL underrun_frame got=%h/%b exp=%h/1", w, bus.o_UNDERRUN, 32'h01000200);
        end
        bus.i_PCM_EN = 1'b0;
        capture_frame(w);
        vectors++;
        if (bus.o_UNDERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_sticky got=%b exp=1", bus.o_UNDERRUN);
        end
        bus.i_PCM_EN = 1'b1;
        for (int i = 0; i < 400 && !is_load(n + 1); i++) tick();
        bus.i_CLR_UNDERRUN = 1'b1;
        tick();
        bus.i_CLR_UNDERRUN = 1'b0;
        vectors++;
        if (bus.o_UNDERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_set_wins got=%b exp=1", bus.o_UNDERRUN);
        end
        bus.i_PCM_EN = 1'b0; bus.i_CLR_UNDERRUN = 1'b1;
        tick();
        bus.i_CLR_UNDERRUN = 1'b0;
        vectors++;
        if (bus.o_UNDERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_clear got=%b exp=0", bus.o_UNDERRUN);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.i_PCM_WR = 1'b1; bus.i_PCM_DATA = $urandom;
            tick();
        end
        bus.i_PCM_WR = 1'b0;
        for (int i = 0; i < 600 && !(m_fall && m_bit == 20); i++) tick();
        vectors++;
        if (bus.o_PCM_LEVEL !== 3'd3) begin
            miscompares++;
            $display("FAIL pre_reset_level got=%0d exp=3", bus.o_PCM_LEVEL);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs_vec() !== 9'h180) begin
            miscompares++;
            $display("FAIL mid_reset_state got=%h exp=%h", obs_vec(), 9'h180);
        end
        rst = 1'b0;
        k = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_FRAME) begin
                k = n;
                break;
            end
        end
        vectors++;
        if (k !== BCK_DIV - 1) begin
            miscompares++;
            $display("FAIL first_frame_clock got=%0d exp=%0d", k, BCK_DIV - 1);
        end
    endtask

    task automatic test_fm_collision();
        logic [31:0] w;
        do_reset();
        bus.i_FM_EN = 1'b1;
        bus.i_FM_L = 16'h0AAA; bus.i_FM_R = 16'h0555; bus.i_FM_VALID = 1'b1;
        tick();
        bus.i_FM_VALID = 1'b0;
        for (int i = 0; i < 400 && !is_load(n + 1); i++) tick();
        bus.i_FM_L = 16'h4321; bus.i_FM_R = 16'hBEEF; bus.i_FM_VALID = 1'b1;
        tick();
        bus.i_FM_VALID = 1'b0;
        capture_frame(w);
        vectors++;
        if (w !== 32'h0AAA0555) begin
            miscompares++;
            $display("FAIL fm_collision_old got=%h exp=%h", w, 32'h0AAA0555);
        end
        capture_frame(w);
        vectors++;
        if (w !== 32'h4321BEEF) begin
            miscompares++;
            $display("FAIL fm_collision_new got=%h exp=%h", w, 32'h4321BEEF);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            bus.i_FM_VALID = ($urandom_range(0, 15) == 0);
            bus.i_FM_L = 16'($urandom); bus.i_FM_R = 16'($urandom);
            bus.i_PCM_WR = ($urandom_range(0, 79) == 0);
            bus.i_PCM_DATA = $urandom;
            if ($urandom_range(0, 99) == 0) bus.i_FM_EN = 1'($urandom);
            if ($urandom_range(0, 99) == 0) bus.i_PCM_EN = 1'($urandom);
            bus.i_CLR_UNDERRUN = ($urandom_range(0, 63) == 0);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random n=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        test_reset();
        test_fm_only();
        test_saturation();
        test_fifo_full();
        test_write_at_pop();
        test_underrun();
        test_mid_reset();
        test_fm_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
